hex_word_serializer: RTL and testbench

//   Streams a WIDTH-bit binary word out as ASCII hex characters, one per handshake,

---
 rtl/hex_ser_pkg.sv | 50 +++++
 rtl/hex_word_serializer.sv | 156 +++++++++++++++
 tb/tb_hex_word_serializer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_ser_pkg.sv
// Shared definitions for the hex print blocks: FSM encoding, ASCII constants and
// the nibble-to-character mapping used by any block that prints hex digits.
package hex_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX0  = 3'd1,
    ST_PFX1  = 3'd2,
    ST_DIGIT = 3'd3,
    ST_TERM0 = 3'd4,
    ST_TERM1 = 3'd5
  } hex_ser_state_e;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_UC_A  = 8'h41;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;

  localparam logic [1:0] TERM_NONE  = 2'd0;
  localparam logic [1:0] TERM_LF    = 2'd1;
  localparam logic [1:0] TERM_CRLF  = 2'd2;
  localparam logic [1:0] TERM_SPACE = 2'd3;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib, input logic lowercase);
    logic [7:0] base_s;
    if (nib < 4'd10) begin
      base_s = ASCII_ZERO;
      return base_s + {4'd0, nib};
    end else begin
      base_s = lowercase ? ASCII_LC_A : ASCII_UC_A;
      return base_s + {4'd0, nib} - 8'd10;
    end
  endfunction

  // First terminator character; CR LF starts with CR, the LF follows in TERM1.
  function automatic logic [7:0] term_first_char(input logic [1:0] mode);
    logic [7:0] c_s;
    case (mode)
      TERM_LF:    c_s = ASCII_LF;
      TERM_CRLF:  c_s = ASCII_CR;
      TERM_SPACE: c_s = ASCII_SPACE;
      default:    c_s = 8'h00;
    endcase
    return c_s;
  endfunction

endpackage

// File: rtl/hex_word_serializer.sv
// Prints a WIDTH-bit word as ASCII hex over a valid/ready byte stream, MS nibble
// first, with optional "0x" prefix and line terminator; feeds a UART transmitter.
module hex_word_serializer
  import hex_ser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit LOWERCASE = 1'b0,
  parameter bit PREFIX_EN = 1'b0,
  parameter int TERM_MODE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int NDIG  = WIDTH / 4;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [1:0]       TERM     = 2'(TERM_MODE);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("hex_word_serializer: WIDTH must be a multiple of 4 and >= 4");
    end
    if (TERM_MODE < 0 || TERM_MODE > 3) begin : g_bad_term
      $error("hex_word_serializer: TERM_MODE must be 0..3");
    end
  endgenerate

  hex_ser_state_e   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted_s;
  logic             accept_s;

  assign shifted_s = shreg_q << 4;
  assign accept_s  = valid_q & out_ready;

  // State, shift register, digit counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      char_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: every accepted character loads its successor on the same edge.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = '0;
          valid_d = 1'b1;
          if (PREFIX_EN) begin
            state_d = ST_PFX0;
            char_d  = ASCII_ZERO;
          end else begin
            state_d = ST_DIGIT;
            char_d  = nibble_to_ascii(in_data[WIDTH-1 -: 4], LOWERCASE);
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_PFX0: begin
        if (accept_s) begin
          state_d = ST_PFX1;
          char_d  = ASCII_X;
        end else begin
          state_d = ST_PFX0;
        end
      end
      ST_PFX1: begin
        if (accept_s) begin
          state_d = ST_DIGIT;
          char_d  = nibble_to_ascii(shreg_q[WIDTH-1 -: 4], LOWERCASE);
        end else begin
          state_d = ST_PFX1;
        end
      end
      ST_DIGIT: begin
        if (accept_s) begin
          if (cnt_q == LAST_DIG) begin
            if (TERM == TERM_NONE) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
            end else begin
              state_d = ST_TERM0;
              char_d  = term_first_char(TERM);
            end
          end else begin
            shreg_d = shifted_s;
            cnt_d   = cnt_q + CNT_W'(1);
            char_d  = nibble_to_ascii(shifted_s[WIDTH-1 -: 4], LOWERCASE);
          end
        end else begin
          state_d = ST_DIGIT;
        end
      end
      ST_TERM0: begin
        if (accept_s) begin
          if (TERM == TERM_CRLF) begin
            state_d = ST_TERM1;
            char_d  = ASCII_LF;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          state_d = ST_TERM0;
        end
      end
      ST_TERM1: begin
        if (accept_s) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_TERM1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE) & rst_n;
  assign busy      = (state_q != ST_IDLE);
  assign out_char  = char_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_hex_word_serializer.sv
// Scoreboard bench: three serializer configurations; expected strings are queued at
// stimulus time and compared against every accepted output character.
module tb_hex_word_serializer;

  logic        clk;
  logic        rst_n;
  logic        out_ready;

  logic [15:0] in_data0, in_data1;
  logic [3:0]  in_data2;
  logic        in_valid0, in_valid1, in_valid2;
  logic        in_ready0, in_ready1, in_ready2;
  logic [7:0]  out_char0, out_char1, out_char2;
  logic        out_valid0, out_valid1, out_valid2;
  logic        busy0, busy1, busy2;

  int n_vec = 0;
  int n_err = 0;

  byte q0[$];
  byte q1[$];
  byte q2[$];

  bit         bp_en   = 1'b0;
  bit         chk_rdy = 1'b0;
  bit         prev_stall[3];
  logic [7:0] prev_char[3];

  hex_word_serializer #(.WIDTH(16), .LOWERCASE(1'b0), .PREFIX_EN(1'b0), .TERM_MODE(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_char(out_char0), .out_valid(out_valid0), .out_ready(out_ready), .busy(busy0));

  hex_word_serializer #(.WIDTH(16), .LOWERCASE(1'b1), .PREFIX_EN(1'b1), .TERM_MODE(2)) u_dut_pfx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .out_char(out_char1), .out_valid(out_valid1), .out_ready(out_ready), .busy(busy1));

  hex_word_serializer #(.WIDTH(4), .LOWERCASE(1'b0), .PREFIX_EN(1'b0), .TERM_MODE(0)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_char(out_char2), .out_valid(out_valid2), .out_ready(out_ready), .busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic qpush(input int inst, input byte c);
    case (inst)
      0: q0.push_back(c);
      1: q1.push_back(c);
      default: q2.push_back(c);
    endcase
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic byte qpop(input int inst);
    case (inst)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic busy_of(input int inst);
    case (inst)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic logic ready_of(input int inst);
    case (inst)
      0: return in_ready0;
      1: return in_ready1;
      default: return in_ready2;
    endcase
  endfunction

  // Reference string builder: table lookup of digits, not arithmetic.
  task automatic push_string(input int inst, input logic [15:0] w);
    string      hex;
    int         ndig;
    bit         lc, pfx;
    int         tm;
    logic [3:0] nib;
    case (inst)
      0: begin ndig = 4; lc = 1'b0; pfx = 1'b0; tm = 2; end
      1: begin ndig = 4; lc = 1'b1; pfx = 1'b1; tm = 2; end
      default: begin ndig = 1; lc = 1'b0; pfx = 1'b0; tm = 0; end
    endcase
    hex = lc ? "0123456789abcdef" : "0123456789ABCDEF";
    if (pfx) begin
      qpush(inst, 8'h30);
      qpush(inst, 8'h78);
    end
    for (int d = ndig - 1; d >= 0; d--) begin
      nib = w[d*4 +: 4];
      qpush(inst, hex[nib]);
    end
    case (tm)
      1: qpush(inst, 8'h0A);
      2: begin qpush(inst, 8'h0D); qpush(inst, 8'h0A); end
      3: qpush(inst, 8'h20);
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int inst, input logic [15:0] w);
    int n = 0;
    while (!ready_of(inst) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check_val("send_timeout", n, 0);
    case (inst)
      0: begin in_data0 = w; in_valid0 = 1'b1; end
      1: begin in_data1 = w; in_valid1 = 1'b1; end
      default: begin in_data2 = w[3:0]; in_valid2 = 1'b1; end
    endcase
    push_string(inst, w);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic drain(input int inst, input bit scramble);
    int n = 0;
    while ((qsize(inst) != 0 || busy_of(inst)) && n < 1000) begin
      @(negedge clk);
      if (scramble) in_data0 = 16'($urandom);
      n++;
    end
    if (n >= 1000) check_val("drain_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic monitor_step(input int i, input logic v, input logic [7:0] c, input logic rdy);
    byte exp;
    if (!rst_n) begin
      prev_stall[i] = 1'b0;
    end else begin
      if (prev_stall[i]) begin
        check_val("stall_valid", v, 1'b1);
        check_val("stall_char", c, prev_char[i]);
      end
      if (i == 0 && chk_rdy && qsize(0) > 0) check_val("t3_rdy_low", rdy, 1'b0);
      if (v && out_ready) begin
        if (qsize(i) == 0) begin
          check_val("spurious_char_q", qsize(i), 1);
        end else begin
          exp = qpop(i);
          check_val($sformatf("char_i%0d", i), c, exp);
        end
      end
      prev_stall[i] = v && !out_ready;
      prev_char[i]  = c;
    end
  endtask

  initial forever begin @(negedge clk); monitor_step(0, out_valid0, out_char0, in_ready0); end
  initial forever begin @(negedge clk); monitor_step(1, out_valid1, out_char1, in_ready1); end
  initial forever begin @(negedge clk); monitor_step(2, out_valid2, out_char2, in_ready2); end

  initial forever begin
    @(posedge clk); #1;
    if (bp_en) out_ready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; out_ready = 1'b1;
    in_data0 = '0; in_data1 = '0; in_data2 = '0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    for (int i = 0; i < 3; i++) begin prev_stall[i] = 1'b0; prev_char[i] = 8'h00; end
    #1 rst_n = 1'b0;
    #2;
    check_val("rst_out_valid", out_valid0, 1'b0);
    check_val("rst_out_char", out_char0, 8'h00);
    check_val("rst_busy", busy0, 1'b0);
    check_val("rst_in_ready", in_ready0, 1'b0);
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_rel_in_ready", in_ready0, 1'b1);

    // 1: BEEF, six back-to-back chars one cycle after accept
    send(0, 16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("t1_valid", out_valid0, 1'b1);
    end
    @(negedge clk);
    check_val("t1_done_valid", out_valid0, 1'b0);
    check_val("t1_done_ready", in_ready0, 1'b1);
    @(posedge clk); #1;

    // 2: prefix + lowercase
    send(1, 16'h00A5);
    drain(1, 1'b0);
    send(1, 16'hC3E9);
    drain(1, 1'b0);

    // 3: random backpressure, input scrambled while busy
    bp_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(0, 16'($urandom));
      chk_rdy = 1'b1;
      drain(0, 1'b1);
      check_val("t3_rdy_after", in_ready0, 1'b1);
      chk_rdy = 1'b0;
    end
    bp_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // 4: in_valid held, 0000 then FFFF, 13 cycles with one idle gap
    in_data0 = 16'h0000; in_valid0 = 1'b1;
    push_string(0, 16'h0000);
    @(posedge clk); #1;
    in_data0 = 16'hFFFF;
    push_string(0, 16'hFFFF);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check_val("t4_valid", out_valid0, (i != 6));
      if (i == 6) begin
        check_val("t4_gap_ready", in_ready0, 1'b1);
        @(posedge clk); #1;
        in_valid0 = 1'b0;
      end
    end
    @(negedge clk);
    check_val("t4_end_valid", out_valid0, 1'b0);
    @(posedge clk); #1;

    // 5: reset after two chars of 1234, then 5678 prints in full
    send(0, 16'h1234);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_val("t5_async_valid", out_valid0, 1'b0);
    check_val("t5_async_busy", busy0, 1'b0);
    check_val("t5_aborted_left", q0.size(), 4);
    q0.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("t5_ready", in_ready0, 1'b1);
    send(0, 16'h5678);
    drain(0, 1'b0);

    // 6: WIDTH=4 without terminator, all nibble values
    for (int v = 0; v < 16; v++) send(2, 16'(v));
    drain(2, 1'b0);

    check_val("left_q0", q0.size(), 0);
    check_val("left_q1", q1.size(), 0);
    check_val("left_q2", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
